// File: rtl/csr_pkg.sv
// Shared definitions for the CSR file: operation encodings, target selectors,
// counter and mirror addresses, and the read-only address range.
package csr_pkg;

    // funct3[1:0] operation field (funct3[2] selects the immediate form)
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // Which storage element a decoded address refers to
    typedef enum logic [2:0] {
        SEL_NONE        = 3'd0,
        SEL_SCRATCH     = 3'd1,
        SEL_MCYCLE_LO   = 3'd2,
        SEL_MCYCLE_HI   = 3'd3,
        SEL_MINSTRET_LO = 3'd4,
        SEL_MINSTRET_HI = 3'd5,
        SEL_MIRROR      = 3'd6
    } csr_sel_e;

    // Writable machine counters (low / high halves)
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // Read-only user mirrors of the machine counters
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // Addresses with bits [11:10] = 2'b11 may never be written
    localparam logic [11:0] CSR_RO_MASK   = 12'hC00;
    localparam logic [11:0] CSR_RO_MATCH  = 12'hC00;

    // True when the address lies in the read-only range
    function automatic logic csr_is_read_only(input logic [11:0] addr);
        return ((addr & CSR_RO_MASK) == CSR_RO_MATCH);
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with independently writable 32-bit halves.
// A write to either half suppresses the increment for that cycle so
// software sees exactly the value it wrote.
module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    output logic [63:0] count
);

    logic [63:0] count_d;
    logic [63:0] count_q;

    // Next count: half writes take priority over the increment, unwritten half holds
    always_comb begin
        count_d = count_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) begin
                count_d[31:0] = wr_data;
            end else begin
                count_d[31:0] = count_q[31:0];
            end
            if (wr_hi) begin
                count_d[63:32] = wr_data;
            end else begin
                count_d[63:32] = count_q[63:32];
            end
        end else if (inc_en) begin
            count_d = count_q + 64'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register, cleared asynchronously by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 64'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// CSR file: scratch registers plus mcycle/minstret counters and their
// read-only mirrors. One request per cycle, response registered one cycle later.
// The read value returned is always the pre-update CSR value.
// XLEN is expected to be at least 32 so counter halves fit in one word.
module csr_file
    import csr_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter int          NUM_SCRATCH  = 4,
    parameter logic [11:0] SCRATCH_BASE = 12'h7C0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            retire,
    output logic            resp_valid,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_we,
    output logic            illegal
);

    localparam logic [11:0] NUM_SCRATCH_W = 12'(NUM_SCRATCH);

    logic [XLEN-1:0] scratch_q [NUM_SCRATCH];
    logic [XLEN-1:0] scratch_d [NUM_SCRATCH];

    logic [63:0]     mcycle_s;
    logic [63:0]     minstret_s;

    csr_op_e         op_s;
    csr_sel_e        sel_s;
    logic [11:0]     scratch_off_s;
    logic [XLEN-1:0] src_s;
    logic [XLEN-1:0] old_s;
    logic [XLEN-1:0] new_s;
    logic            write_act_s;
    logic            illegal_s;
    logic            do_write_s;
    logic            rd_we_s;

    logic            mc_wr_lo_s;
    logic            mc_wr_hi_s;
    logic            mi_wr_lo_s;
    logic            mi_wr_hi_s;
    logic [31:0]     cnt_wdata_s;

    logic            resp_valid_d;
    logic            resp_valid_q;
    logic [XLEN-1:0] rd_data_d;
    logic [XLEN-1:0] rd_data_q;
    logic            rd_we_d;
    logic            rd_we_q;
    logic            illegal_d;
    logic            illegal_q;

    // Operand decode: operation, source operand and offset into the scratch window
    always_comb begin
        op_s = csr_op_e'(funct3[1:0]);
        if (funct3[2]) begin
            src_s = XLEN'(rs1_addr);
        end else begin
            src_s = rs1_data;
        end
        scratch_off_s = csr_addr - SCRATCH_BASE;
    end

    // Address decode and read mux; counter halves are zero-extended to XLEN
    always_comb begin
        sel_s = SEL_NONE;
        old_s = {XLEN{1'b0}};
        case (csr_addr)
            CSR_MCYCLE: begin
                sel_s = SEL_MCYCLE_LO;
                old_s = XLEN'(mcycle_s[31:0]);
            end
            CSR_MCYCLEH: begin
                sel_s = SEL_MCYCLE_HI;
                old_s = XLEN'(mcycle_s[63:32]);
            end
            CSR_MINSTRET: begin
                sel_s = SEL_MINSTRET_LO;
                old_s = XLEN'(minstret_s[31:0]);
            end
            CSR_MINSTRETH: begin
                sel_s = SEL_MINSTRET_HI;
                old_s = XLEN'(minstret_s[63:32]);
            end
            CSR_CYCLE: begin
                sel_s = SEL_MIRROR;
                old_s = XLEN'(mcycle_s[31:0]);
            end
            CSR_CYCLEH: begin
                sel_s = SEL_MIRROR;
                old_s = XLEN'(mcycle_s[63:32]);
            end
            CSR_INSTRET: begin
                sel_s = SEL_MIRROR;
                old_s = XLEN'(minstret_s[31:0]);
            end
            CSR_INSTRETH: begin
                sel_s = SEL_MIRROR;
                old_s = XLEN'(minstret_s[63:32]);
            end
            default: begin
                // Addresses below the base wrap to large offsets and miss
                if (scratch_off_s < NUM_SCRATCH_W) begin
                    sel_s = SEL_SCRATCH;
                    for (int i = 0; i < NUM_SCRATCH; i++) begin
                        old_s = (scratch_off_s == 12'(i)) ? scratch_q[i] : old_s;
                    end
                end else begin
                    sel_s = SEL_NONE;
                    old_s = {XLEN{1'b0}};
                end
            end
        endcase
    end

    // Legality, write intent, new value and destination write enable
    always_comb begin
        write_act_s = 1'b0;
        new_s       = old_s;
        case (op_s)
            CSR_OP_RW: write_act_s = 1'b1;
            CSR_OP_RS: write_act_s = (rs1_addr != 5'd0);
            CSR_OP_RC: write_act_s = (rs1_addr != 5'd0);
            default:   write_act_s = 1'b0;
        endcase

        case (op_s)
            CSR_OP_RW: new_s = src_s;
            CSR_OP_RS: new_s = old_s | src_s;
            CSR_OP_RC: new_s = old_s & ~src_s;
            default:   new_s = old_s;
        endcase

        illegal_s  = req_valid
                   & ((op_s == CSR_OP_NONE)
                   | (sel_s == SEL_NONE)
                   | (write_act_s & csr_is_read_only(csr_addr)));
        do_write_s = req_valid & write_act_s & ~illegal_s;
        // CSRRW to x0 must not even appear to read the CSR
        rd_we_s    = req_valid & ~illegal_s
                   & ~((op_s == CSR_OP_RW) & (rd_addr == 5'd0));
    end

    // Per-half write strobes for the two counters
    always_comb begin
        mc_wr_lo_s  = do_write_s & (sel_s == SEL_MCYCLE_LO);
        mc_wr_hi_s  = do_write_s & (sel_s == SEL_MCYCLE_HI);
        mi_wr_lo_s  = do_write_s & (sel_s == SEL_MINSTRET_LO);
        mi_wr_hi_s  = do_write_s & (sel_s == SEL_MINSTRET_HI);
        cnt_wdata_s = new_s[31:0];
    end

    // Scratch next state: only the addressed entry takes the new value
    always_comb begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (do_write_s && (sel_s == SEL_SCRATCH) && (scratch_off_s == 12'(i))) begin
                scratch_d[i] = new_s;
            end else begin
                scratch_d[i] = scratch_q[i];
            end
        end
    end

    // Response next state; everything is zero when no request was presented
    always_comb begin
        resp_valid_d = req_valid;
        if (req_valid && !illegal_s) begin
            rd_data_d = old_s;
        end else begin
            rd_data_d = {XLEN{1'b0}};
        end
        rd_we_d   = rd_we_s;
        illegal_d = illegal_s;
    end

    // Scratch storage and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= {XLEN{1'b0}};
            end
            resp_valid_q <= 1'b0;
            rd_data_q    <= {XLEN{1'b0}};
            rd_we_q      <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= scratch_d[i];
            end
            resp_valid_q <= resp_valid_d;
            rd_data_q    <= rd_data_d;
            rd_we_q      <= rd_we_d;
            illegal_q    <= illegal_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_en  (1'b1),
        .wr_lo   (mc_wr_lo_s),
        .wr_hi   (mc_wr_hi_s),
        .wr_data (cnt_wdata_s),
        .count   (mcycle_s)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_en  (retire),
        .wr_lo   (mi_wr_lo_s),
        .wr_hi   (mi_wr_hi_s),
        .wr_data (cnt_wdata_s),
        .count   (minstret_s)
    );

    assign resp_valid = resp_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_we      = rd_we_q;
    assign illegal    = illegal_q;

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter XLEN, default 32: data width of scratch CSRs, rs1 operand and read data.
REQ-002 Parameter NUM_SCRATCH, default 4: number of read/write scratch CSRs (1..16).
REQ-003 Parameter SCRATCH_BASE, default 12'h7C0: address of scratch CSR 0; scratch i is at SCRATCH_BASE+i.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  CSR instruction presented this cycle.
REQ-007 funct3  input  3  CSR operation: bit2 = immediate form, bits[1:0] 01 RW, 10 RS, 11 RC.
REQ-008 csr_addr  input  12  target CSR address.
REQ-009 rs1_addr  input  5  rs1 index, or uimm[4:0] in immediate form.
REQ-010 rd_addr  input  5  destination register index.
REQ-011 rs1_data  input  XLEN  rs1 value.
REQ-012 retire  input  1  one-cycle pulse per retired instruction.
REQ-013 resp_valid  output  1  response for the request accepted on the previous edge.
REQ-014 rd_data  output  XLEN  old CSR value (counter halves zero-extended to XLEN).
REQ-015 rd_we  output  1  rd_data is to be written to rd.
REQ-016 illegal  output  1  request was an illegal CSR access.

Function
REQ-017 Latency: a request sampled at edge N SHALL produce resp_valid=1 and rd_data/rd_we/illegal in the cycle after N; a new request is accepted every cycle.
REQ-018 Source operand: src = rs1_data when funct3[2]=0, else zero-extended rs1_addr.
REQ-019 New value: RW → src; RS → old|src; RC → old&~src; CSR update at edge N, visible to a request at edge N+1.
REQ-020 RW with rd_addr=0 → rd_we=0; RS/RC with rs1_addr=0 → no CSR write, read still performed.
REQ-021 Mapped CSRs: scratch[0..NUM_SCRATCH-1] (RW); mcycle 12'hB00/12'hB80 and minstret 12'hB02/12'hB82 (low/high 32 bits, RW); cycle 12'hC00/12'hC80 and instret 12'hC02/12'hC82 (read-only mirrors).
REQ-022 illegal=1 when funct3[1:0]=00, csr_addr unmapped, or an actual write targets addr[11:10]=2'b11; on illegal: no CSR change, rd_we=0.
REQ-023 mcycle (64-bit) SHALL increment by 1 every cycle not in reset; minstret (64-bit) by 1 on each cycle retire=1.
REQ-024 Carry from low to high half; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-025 CSR write to a counter half in the same cycle as its increment: written half takes the written value, no increment applies to either half that cycle.
REQ-026 Writing one half leaves the other half unchanged.
REQ-027 resp_valid=0 in cycles after edges where req_valid=0; rd_data, rd_we, illegal then 0.

Reset
REQ-028 While rst=1: all scratch CSRs, mcycle, minstret = 0; resp_valid, rd_we, illegal = 0; rd_data = 0.
REQ-029 A request in flight when rst asserts is discarded; no CSR write occurs.
REQ-030 First counter increment on the first rising edge after rst deasserts.

Structure
REQ-031 Package csr_pkg holds funct3 encodings, counter/mirror address constants and the illegal-range mask.
REQ-032 Sub-module csr_counter64 (increment enable, per-half write enable/data) instantiated for mcycle and minstret.

Verification
REQ-033 CSRRW scratch0 (0x7C0) rs1_data=0xDEADBEEF, rd=5 → rd_data=0, rd_we=1; next CSRRS rs1=0 reads 0xDEADBEEF with no write.
REQ-034 CSRRCI 0x7C1 holding 0xFF, uimm=0x0F → rd_data=0xFF, register becomes 0xF0.
REQ-035 Write mcycle low=0xFFFFFFFF, high=0 → two cycles later read of 0xB80 returns 1.
REQ-036 CSRRW to 0xC00 → illegal=1, rd_we=0; CSRRS 0xC00 rs1=0 → illegal=0, returns cycle count.
REQ-037 retire pulse coincident with CSRRW 0xB02=0x10 → minstret low=0x10 next cycle, not 0x11.
REQ-038 Assert rst mid-stream with writes pending → all outputs 0, scratch reads 0 after release.
